crc_frame_sequencer: RTL
========================

CRC_FRAME_SEQUENCER -- requirements
Module: crc_frame_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 16, SHALL set the maximum payload byte count (legal 1..255).
REQ-002 Parameter POLY, default 8'h07, SHALL set the CRC-8 generator polynomial (x^8+x^2+x+1).
REQ-003 Parameter INIT, default 8'h00, SHALL set the CRC register start value per frame.
REQ-004 Parameter TIMEOUT_CYCLES, default 1000, SHALL set the inter-byte timeout in clk cycles.
REQ-005 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 reset_n  input  1  reset; asynchronous, active-low.
REQ-007 rx_data  input  8  received byte; rx_valid  input  1  one-cycle byte strobe from the UART receiver.
REQ-008 abort  input  1  synchronous frame abort.
REQ-009 payload_data  output  8 and payload_valid  output  1 SHALL be the forwarded payload byte and its one-cycle strobe.
REQ-010 frame_done  output  1, frame_ok  output  1 and crc_error  output  1 SHALL be the end-of-frame pulse and result flags.
REQ-011 len_error  output  1 and timeout_error  output  1 SHALL be one-cycle error pulses; busy  output  1 SHALL be high while a frame is open.
REQ-012 ok_count  output  16 and err_count  output  16 SHALL count good and failed frames.

Function
REQ-013 Frame format SHALL be: LEN byte, LEN payload bytes, one CRC byte; CRC SHALL cover LEN and payload, MSB-first, bytewise, no reflection, no final XOR.
REQ-014 The CRC register SHALL update in the same cycle a byte is accepted: crc <= byte_crc(crc ^ rx_data), 8 shift/XOR steps with POLY.
REQ-015 States SHALL be IDLE, PAYLOAD and CRC_WAIT; busy SHALL be high in PAYLOAD and CRC_WAIT.
REQ-016 IDLE + rx_valid with rx_data in 1..MAX_LEN SHALL load crc from INIT, load the remaining-byte counter with rx_data, and go to PAYLOAD.
REQ-017 IDLE + rx_valid with rx_data==0 or >MAX_LEN SHALL pulse len_error the next cycle, increment err_count, and stay in IDLE.
REQ-018 PAYLOAD + rx_valid SHALL update crc, decrement the counter and drive payload_data/payload_valid the next cycle; on counter==1 the FSM SHALL go to CRC_WAIT.
REQ-019 CRC_WAIT + rx_valid SHALL compare rx_data to crc and, one cycle later, pulse frame_done with frame_ok=match and crc_error=!match, then go to IDLE.
REQ-020 frame_ok and crc_error SHALL hold their value until the next frame_done; ok_count or err_count SHALL increment on each frame_done.
REQ-021 Counters SHALL wrap from 16'hFFFF to 0.
REQ-022 abort SHALL return the FSM to IDLE with no frame_done, no error pulse and no counter change; abort and rx_valid in the same cycle SHALL drop the byte.
REQ-023 rx_valid outside a frame SHALL only be interpreted as a LEN byte; there SHALL be no back-pressure.

Reset
REQ-024 Asserting reset_n low SHALL immediately force IDLE, crc=INIT and a counter value of 0.
REQ-025 While reset_n is low, all outputs SHALL be 0, including ok_count and err_count.
REQ-026 Reset mid-frame SHALL discard the frame with no pulses on release.

Configuration
REQ-027 With CRC_TIMEOUT_EN defined, an idle-cycle counter SHALL run in PAYLOAD/CRC_WAIT and clear on each rx_valid.
REQ-028 With CRC_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without rx_valid SHALL pulse timeout_error, increment err_count and return to IDLE.
REQ-029 Without CRC_TIMEOUT_EN, no timeout logic SHALL exist, timeout_error SHALL be tied to 0, and a frame SHALL remain open indefinitely.

Verification
REQ-030 Bytes 01 00 15 -> one payload_valid with 0x00; frame_done, frame_ok=1 and ok_count=1.
REQ-031 Bytes 02 01 02 CD -> payload 0x01, 0x02; frame_ok=1. Bytes 02 01 02 CC -> crc_error=1 and err_count=1.
REQ-032 LEN 0x00, then LEN 0x11 (MAX_LEN=16) -> two len_error pulses, FSM stays IDLE, err_count=2; a following 01 00 15 -> frame_ok.
REQ-033 With CRC_TIMEOUT_EN: 02 01 then 1000 idle cycles -> timeout_error pulse and busy=0; a following 01 00 15 -> frame_ok.
REQ-034 02 01 then abort together with rx_valid(0x02) -> no payload byte, no frame_done, busy=0; counters unchanged.
REQ-035 reset_n low after 02 01 -> all outputs 0; after release, 01 00 15 -> frame_ok and ok_count=1.

Source files
------------

// File: rtl/crc_frame_sequencer_if.sv
// Byte-stream and result signals between a UART receiver/consumer and crc_frame_sequencer.
// master = traffic source and result consumer, slave = the sequencer.
interface crc_frame_sequencer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        abort;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic        frame_done;
  logic        frame_ok;
  logic        crc_error;
  logic        len_error;
  logic        timeout_error;
  logic        busy;
  logic [15:0] ok_count;
  logic [15:0] err_count;

  modport master (
    output rx_data, rx_valid, abort,
    input  payload_data, payload_valid, frame_done, frame_ok, crc_error,
           len_error, timeout_error, busy, ok_count, err_count
  );

  modport slave (
    input  rx_data, rx_valid, abort,
    output payload_data, payload_valid, frame_done, frame_ok, crc_error,
           len_error, timeout_error, busy, ok_count, err_count
  );
endinterface

// File: rtl/crc_frame_sequencer.sv
// Parses LEN / payload / CRC-8 frames, forwards payload bytes and reports per-frame status.
// Optional inter-byte timeout enabled by defining CRC_TIMEOUT_EN.
module crc_frame_sequencer #(
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  POLY           = 8'h07,
  parameter logic [7:0]  INIT           = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  crc_frame_sequencer_if.slave   bus
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CRC_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_crc, w_crc_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_payload_data, w_pd_nxt;
  logic        r_payload_valid, w_pv_nxt;
  logic        r_frame_done, w_fd_nxt;
  logic        r_frame_ok, w_ok_nxt;
  logic        r_crc_error, w_cerr_nxt;
  logic        r_len_error, w_le_nxt;
  logic [15:0] r_ok_count, w_okc_nxt;
  logic [15:0] r_err_count, w_errc_nxt;
  logic        w_timeout;
  logic        w_match;

  function automatic logic [7:0] byte_crc(input logic [7:0] c_in);
    logic [7:0] c;
    c = c_in;
    for (int unsigned i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
    return c;
  endfunction

`ifdef CRC_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_idle;
  logic          r_timeout_error;

  assign w_timeout = (r_state != IDLE) && !bus.rx_valid && !bus.abort &&
                     (r_idle == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle          <= '0;
      r_timeout_error <= 1'b0;
    end else begin
      r_timeout_error <= w_timeout;
      if (r_state == IDLE || bus.rx_valid || bus.abort) r_idle <= '0;
      else                                              r_idle <= r_idle + 1'b1;
    end
  end

  assign bus.timeout_error = r_timeout_error;
`else
  assign w_timeout         = 1'b0;
  assign bus.timeout_error = 1'b0;
`endif

  assign w_match = (bus.rx_data == r_crc);

  always_comb begin
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_cnt_nxt   = r_cnt;
    w_pd_nxt    = r_payload_data;
    w_pv_nxt    = 1'b0;
    w_fd_nxt    = 1'b0;
    w_ok_nxt    = r_frame_ok;
    w_cerr_nxt  = r_crc_error;
    w_le_nxt    = 1'b0;
    w_okc_nxt   = r_ok_count;
    w_errc_nxt  = r_err_count;
    // abort outranks everything, including a byte arriving in the same cycle
    if (bus.abort) begin
      w_state_nxt = IDLE;
    end else if (w_timeout) begin
      w_state_nxt = IDLE;
      w_errc_nxt  = r_err_count + 16'd1;
    end else if (bus.rx_valid) begin
      unique case (r_state)
        IDLE: begin
          if (bus.rx_data != 8'd0 && bus.rx_data <= MAX_LEN_B) begin
            w_crc_nxt   = byte_crc(INIT ^ bus.rx_data);
            w_cnt_nxt   = bus.rx_data;
            w_state_nxt = PAYLOAD;
          end else begin
            w_le_nxt   = 1'b1;
            w_errc_nxt = r_err_count + 16'd1;
          end
        end
        PAYLOAD: begin
          w_crc_nxt = byte_crc(r_crc ^ bus.rx_data);
          w_cnt_nxt = r_cnt - 8'd1;
          w_pd_nxt  = bus.rx_data;
          w_pv_nxt  = 1'b1;
          if (r_cnt == 8'd1) w_state_nxt = CRC_WAIT;
        end
        CRC_WAIT: begin
          w_fd_nxt    = 1'b1;
          w_ok_nxt    = w_match;
          w_cerr_nxt  = !w_match;
          if (w_match) w_okc_nxt  = r_ok_count + 16'd1;
          else         w_errc_nxt = r_err_count + 16'd1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_crc           <= INIT;
      r_cnt           <= '0;
      r_payload_data  <= '0;
      r_payload_valid <= 1'b0;
      r_frame_done    <= 1'b0;
      r_frame_ok      <= 1'b0;
      r_crc_error     <= 1'b0;
      r_len_error     <= 1'b0;
      r_ok_count      <= '0;
      r_err_count     <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_crc           <= w_crc_nxt;
      r_cnt           <= w_cnt_nxt;
      r_payload_data  <= w_pd_nxt;
      r_payload_valid <= w_pv_nxt;
      r_frame_done    <= w_fd_nxt;
      r_frame_ok      <= w_ok_nxt;
      r_crc_error     <= w_cerr_nxt;
      r_len_error     <= w_le_nxt;
      r_ok_count      <= w_okc_nxt;
      r_err_count     <= w_errc_nxt;
    end
  end

  assign bus.payload_data  = r_payload_data;
  assign bus.payload_valid = r_payload_valid;
  assign bus.frame_done    = r_frame_done;
  assign bus.frame_ok      = r_frame_ok;
  assign bus.crc_error     = r_crc_error;
  assign bus.len_error     = r_len_error;
  assign bus.busy          = (r_state != IDLE);
  assign bus.ok_count      = r_ok_count;
  assign bus.err_count     = r_err_count;

endmodule
